// File: rtl/check_dbg_pkg.sv
// Shared types and constants for the pipeline debug check mux and its snapshot scanner.
// Address constants name the 25 forwarding, hazard, stall and flush probes.
package check_dbg_pkg;

   localparam int NUM_CHK = 25;
   localparam int AW      = 5;
   localparam int DW      = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_STREAM  = 2'd3
   } snap_state_t;

   localparam logic [AW-1:0] CHK_RF_RA0    = 5'd0;
   localparam logic [AW-1:0] CHK_RF_RA1    = 5'd1;
   localparam logic [AW-1:0] CHK_RF_RD0    = 5'd2;
   localparam logic [AW-1:0] CHK_RF_RD1    = 5'd3;
   localparam logic [AW-1:0] CHK_FWD_A     = 5'd4;
   localparam logic [AW-1:0] CHK_FWD_B     = 5'd5;
   localparam logic [AW-1:0] CHK_RD0_EX    = 5'd6;
   localparam logic [AW-1:0] CHK_RD1_EX    = 5'd7;
   localparam logic [AW-1:0] CHK_ALU_OUT   = 5'd8;
   localparam logic [AW-1:0] CHK_MEM_ADDR  = 5'd9;
   localparam logic [AW-1:0] CHK_MEM_WD    = 5'd10;
   localparam logic [AW-1:0] CHK_WB_SEL    = 5'd11;
   localparam logic [AW-1:0] CHK_RF_WA_WB  = 5'd12;
   localparam logic [AW-1:0] CHK_RF_WD_WB  = 5'd13;
   localparam logic [AW-1:0] CHK_RF_RD0_FE = 5'd14;
   localparam logic [AW-1:0] CHK_RF_RD1_FE = 5'd15;
   localparam logic [AW-1:0] CHK_FWD_A_ID  = 5'd16;
   localparam logic [AW-1:0] CHK_FWD_B_ID  = 5'd17;
   localparam logic [AW-1:0] CHK_HAZ_LOAD  = 5'd18;
   localparam logic [AW-1:0] CHK_HAZ_BR    = 5'd19;
   localparam logic [AW-1:0] CHK_STALL_IF  = 5'd20;
   localparam logic [AW-1:0] CHK_STALL_ID  = 5'd21;
   localparam logic [AW-1:0] CHK_FLUSH_ID  = 5'd22;
   localparam logic [AW-1:0] CHK_FLUSH_EX  = 5'd23;
   localparam logic [AW-1:0] CHK_FLUSH_MEM = 5'd24;

endpackage

// File: rtl/check_snap_buf.sv
// Snapshot buffer: NUM_CHK words with per-entry changed flag and
// "has a previous sample" flag; one write/compare port, one comb read port.
module check_snap_buf #(
   parameter int NUM_CHK = 25,
   parameter int AW      = 5,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [DW-1:0] rd_data,
   output logic          rd_chg
);
   import check_dbg_pkg::*;

   logic [DW-1:0]      r_buf [NUM_CHK];
   logic [NUM_CHK-1:0] r_chg;
   logic [NUM_CHK-1:0] r_prev_vld;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            r_buf[i] <= '0;
         end
         r_chg      <= '0;
         r_prev_vld <= '0;
      end else if (wr_en) begin
         r_buf[wr_idx]      <= wr_data;
         r_chg[wr_idx]      <= (wr_data != r_buf[wr_idx])
                               | ~r_prev_vld[wr_idx];
         r_prev_vld[wr_idx] <= 1'b1;
      end
   end

   assign rd_data = r_buf[rd_idx];
   assign rd_chg  = r_chg[rd_idx];

endmodule

// File: rtl/check_snapshot_scanner.sv
// Freezes the CPU, sweeps the debug check mux into a snapshot buffer,
// then streams the words out with valid/ready and a changed-since-last flag.
module check_snapshot_scanner #(
   parameter int NUM_CHK = check_dbg_pkg::NUM_CHK,
   parameter int AW      = check_dbg_pkg::AW,
   parameter int DW      = check_dbg_pkg::DW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          snap_req,
   output logic          busy,
   output logic          cpu_hold,
   output logic [AW-1:0] check_addr,
   input  logic [DW-1:0] check_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_idx,
   output logic          out_changed,
   output logic          out_last,
   output logic [15:0]   snap_cnt
);
   import check_dbg_pkg::*;

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CHK - 1);

   snap_state_t   r_state;
   snap_state_t   w_state_nxt;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] w_idx_nxt;
   logic          r_cpu_hold;
   logic [15:0]   r_snap_cnt;
   logic          w_wr_en;
   logic          w_done;
   logic [DW-1:0] w_rd_data;
   logic          w_rd_chg;
   logic          w_is_last;

   assign w_is_last = (r_idx == LAST_IDX);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr_en     = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (snap_req) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_state_nxt = ST_CAPTURE;
            w_idx_nxt   = '0;
         end
         ST_CAPTURE: begin
            w_wr_en = 1'b1;
            if (w_is_last) begin
               w_state_nxt = ST_STREAM;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         ST_STREAM: begin
            if (out_ready) begin
               if (w_is_last) begin
                  w_state_nxt = ST_IDLE;
                  w_idx_nxt   = '0;
                  w_done      = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // cpu_hold is registered from next state so it is already high in HOLD
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_cpu_hold <= 1'b0;
         r_snap_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_cpu_hold <= (w_state_nxt == ST_HOLD)
                       || (w_state_nxt == ST_CAPTURE);
         if (w_done) begin
            r_snap_cnt <= r_snap_cnt + 16'd1;
         end
      end
   end

   check_snap_buf #(
      .NUM_CHK (NUM_CHK),
      .AW      (AW),
      .DW      (DW)
   ) u_buf (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (w_wr_en),
      .wr_idx  (r_idx),
      .wr_data (check_data),
      .rd_idx  (r_idx),
      .rd_data (w_rd_data),
      .rd_chg  (w_rd_chg)
   );

   assign busy        = (r_state != ST_IDLE);
   assign cpu_hold    = r_cpu_hold;
   assign check_addr  = (r_state == ST_CAPTURE) ? r_idx : '0;
   assign out_valid   = (r_state == ST_STREAM);
   assign out_data    = out_valid ? w_rd_data : '0;
   assign out_idx     = out_valid ? r_idx : '0;
   assign out_changed = out_valid & w_rd_chg;
   assign out_last    = out_valid & w_is_last;
   assign snap_cnt    = r_snap_cnt;

endmodule

// File: tb/tb_check_snapshot_scanner.sv
// Directed bench for check_snapshot_scanner: sweep timing, change flags,
// backpressure, ignored requests, mid-capture reset and counter wrap.
module tb_check_snapshot_scanner;

   logic        clk;
   logic        rstn;
   logic        snap_req;
   logic        busy;
   logic        cpu_hold;
   logic [4:0]  check_addr;
   logic [31:0] check_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_idx;
   logic        out_changed;
   logic        out_last;
   logic [15:0] snap_cnt;

   logic [31:0] mdl [25];
   logic [31:0] cap_data [25];
   logic        cap_chg [25];

   int checks;
   int errors;
   int n_xfer;
   int hold_err;
   int addr_err;
   int order_err;
   int last_err;
   int stab_err;
   int first_v;
   int end_c;

   check_snapshot_scanner dut (
      .clk         (clk),
      .rstn        (rstn),
      .snap_req    (snap_req),
      .busy        (busy),
      .cpu_hold    (cpu_hold),
      .check_addr  (check_addr),
      .check_data  (check_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_idx     (out_idx),
      .out_changed (out_changed),
      .out_last    (out_last),
      .snap_cnt    (snap_cnt)
   );

   assign check_data = (int'(check_addr) < 25) ? mdl[int'(check_addr)] : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_snap(input bit bp, input int p1, input int p2);
      bit          done;
      bit          pstall;
      int          k;
      int          exp_addr;
      logic [31:0] pd;
      logic [4:0]  pi;
      logic        pl;
      n_xfer = 0; hold_err = 0; addr_err = 0; order_err = 0;
      last_err = 0; stab_err = 0; first_v = 0; end_c = 0;
      done = 0; pstall = 0; k = 0; pd = '0; pi = '0; pl = 1'b0;
      for (int i = 0; i < 25; i++) begin
         cap_data[i] = 32'hx;
         cap_chg[i]  = 1'bx;
      end
      @(negedge clk);
      snap_req  = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 300 && !done; c++) begin
         @(negedge clk);
         if (cpu_hold !== (c <= 26)) hold_err++;
         exp_addr = (c >= 2 && c <= 26) ? c - 2 : 0;
         if (int'(check_addr) != exp_addr) addr_err++;
         if (pstall && (out_valid !== 1'b1 || out_data !== pd
                        || out_idx !== pi || out_last !== pl)) stab_err++;
         if (!busy) begin
            done  = 1;
            end_c = c;
         end else begin
            snap_req = (c == p1 || c == p2);
            if (out_valid) begin
               if (first_v == 0) first_v = c;
               out_ready = bp ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
               k++;
               if (out_ready) begin
                  if (int'(out_idx) != n_xfer) order_err++;
                  if (out_last !== (n_xfer == 24)) last_err++;
                  if (n_xfer < 25) begin
                     cap_data[n_xfer] = out_data;
                     cap_chg[n_xfer]  = out_changed;
                  end
                  n_xfer++;
               end
               pstall = !out_ready;
               pd = out_data; pi = out_idx; pl = out_last;
            end else begin
               out_ready = 1'b1;
               pstall    = 0;
            end
         end
      end
      snap_req  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL snapshot_timeout: busy=%0b after 300 cycles, required 0", busy);
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0; snap_req = 1'b0; out_ready = 1'b1;
      #12;
      checks++;
      if ({busy, cpu_hold, out_valid, out_changed, out_last} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 00000",
                  {busy, cpu_hold, out_valid, out_changed, out_last});
      end
      checks++;
      if (check_addr !== 5'd0 || out_idx !== 5'd0) begin
         errors++;
         $display("FAIL reset_addr: check_addr=%0d out_idx=%0d required 0 0",
                  check_addr, out_idx);
      end
      checks++;
      if (out_data !== 32'h0 || snap_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_data: out_data=%h snap_cnt=%h required 0 0",
                  out_data, snap_cnt);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_first_snap;
      for (int i = 0; i < 25; i++) mdl[i] = i * 32'h11111111;
      run_snap(1'b0, -1, -1);
      checks++;
      if (hold_err != 0) begin
         errors++;
         $display("FAIL first_cpu_hold: %0d bad cycles required 0", hold_err);
      end
      checks++;
      if (addr_err != 0) begin
         errors++;
         $display("FAIL first_check_addr: %0d bad cycles required 0", addr_err);
      end
      checks++;
      if (first_v != 27 || end_c != 52) begin
         errors++;
         $display("FAIL first_latency: first_valid=%0d idle=%0d required 27 52",
                  first_v, end_c);
      end
      checks++;
      if (n_xfer != 25 || order_err != 0 || last_err != 0) begin
         errors++;
         $display("FAIL first_stream: xfers=%0d order_err=%0d last_err=%0d required 25 0 0",
                  n_xfer, order_err, last_err);
      end
      for (int i = 0; i < 25; i++) begin
         checks++;
         if (cap_data[i] !== i * 32'h11111111 || cap_chg[i] !== 1'b1) begin
            errors++;
            $display("FAIL first_word%0d: data=%h chg=%b required %h 1",
                     i, cap_data[i], cap_chg[i], i * 32'h11111111);
         end
      end
      checks++;
      if (snap_cnt !== 16'd1) begin
         errors++;
         $display("FAIL first_snap_cnt: got %0d required 1", snap_cnt);
      end
   endtask

   task automatic test_change_one;
      mdl[8] = 32'hDEADBEEF;
      run_snap(1'b0, -1, -1);
      for (int i = 0; i < 25; i++) begin
         checks++;
         if (cap_data[i] !== mdl[i] || cap_chg[i] !== (i == 8)) begin
            errors++;
            $display("FAIL change_word%0d: data=%h chg=%b required %h %b",
                     i, cap_data[i], cap_chg[i], mdl[i], (i == 8));
         end
      end
      checks++;
      if (snap_cnt !== 16'd2) begin
         errors++;
         $display("FAIL change_snap_cnt: got %0d required 2", snap_cnt);
      end
   endtask

   task automatic test_backpressure;
      int bad;
      run_snap(1'b1, -1, -1);
      checks++;
      if (n_xfer != 25 || order_err != 0 || stab_err != 0) begin
         errors++;
         $display("FAIL bp_stream: xfers=%0d order_err=%0d stab_err=%0d required 25 0 0",
                  n_xfer, order_err, stab_err);
      end
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         if (cap_data[i] !== mdl[i] || cap_chg[i] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_words: %0d wrong words required 0", bad);
      end
      checks++;
      if (snap_cnt !== 16'd3) begin
         errors++;
         $display("FAIL bp_snap_cnt: got %0d required 3", snap_cnt);
      end
   endtask

   task automatic test_ignore_req;
      run_snap(1'b0, 10, 35);
      checks++;
      if (n_xfer != 25 || end_c != 52) begin
         errors++;
         $display("FAIL ignore_stream: xfers=%0d idle=%0d required 25 52",
                  n_xfer, end_c);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || snap_cnt !== 16'd4) begin
         errors++;
         $display("FAIL ignore_after: busy=%b snap_cnt=%0d required 0 4",
                  busy, snap_cnt);
      end
   endtask

   task automatic test_reset_mid;
      int nchg;
      @(negedge clk);
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      repeat (11) @(negedge clk);
      checks++;
      if (check_addr !== 5'd10 || cpu_hold !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: check_addr=%0d cpu_hold=%b required 10 1",
                  check_addr, cpu_hold);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({busy, cpu_hold, out_valid, out_changed, out_last} !== 5'b0
          || check_addr !== 5'd0 || snap_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: flags=%b addr=%0d cnt=%0d required 00000 0 0",
                  {busy, cpu_hold, out_valid, out_changed, out_last},
                  check_addr, snap_cnt);
      end
      @(negedge clk);
      rstn = 1'b1;
      run_snap(1'b0, -1, -1);
      nchg = 0;
      for (int i = 0; i < 25; i++) begin
         if (cap_chg[i] === 1'b1 && cap_data[i] === mdl[i]) nchg++;
      end
      checks++;
      if (nchg != 25 || snap_cnt !== 16'd1) begin
         errors++;
         $display("FAIL mid_after: changed=%0d snap_cnt=%0d required 25 1",
                  nchg, snap_cnt);
      end
   endtask

   task automatic test_wrap;
      @(negedge clk);
      force dut.r_snap_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_snap_cnt;
      @(negedge clk);
      checks++;
      if (snap_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_pre: got %h required ffff", snap_cnt);
      end
      run_snap(1'b0, -1, -1);
      checks++;
      if (snap_cnt !== 16'h0000 || n_xfer != 25) begin
         errors++;
         $display("FAIL wrap_post: snap_cnt=%h xfers=%0d required 0000 25",
                  snap_cnt, n_xfer);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 25; i++) mdl[i] = 32'h0;
      test_reset;
      test_first_snap;
      test_change_one;
      test_backpressure;
      test_ignore_req;
      test_reset_mid;
      test_wrap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
